// File: rtl/fft_power_binner.sv
// fft_power_binner: |X|^2 per bin for the first 1024 bins of each 2048-sample FFT output block.
// Optional FFT_PWR_LOG2_EN adds a third stage that converts the power into a 10-bit log2 code.
module fft_power_binner (
    input  logic        clk,
    input  logic        rstn,
    input  logic        obstart,
    input  logic        outvalid,
    input  logic [15:0] dore,
    input  logic [15:0] doim,
    input  logic        except,
    output logic        pwr_valid,
    output logic [31:0] pwr_data,
    output logic [9:0]  pwr_bin,
    output logic        pwr_first,
    output logic        pwr_last,
    output logic        frame_done,
    output logic        frame_err,
    output logic        except_flag
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [10:0] cnt;
    logic [10:0] idx;
    logic        start;
    logic        accept;
    logic        restart;

    // A start always wins: it is the only way out of IDLE and also aborts a running block.
    assign start   = outvalid & obstart;
    assign accept  = start | (outvalid & (state != ST_IDLE));
    assign restart = start & (state != ST_IDLE);
    assign idx     = start ? 11'd0 : cnt;

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = ST_RUN;
        end else if (accept && state == ST_RUN && idx == 11'd1023) begin
            state_nxt = ST_DRAIN;
        end else if (accept && state == ST_DRAIN && idx == 11'd2047) begin
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
            cnt   <= 11'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt <= idx + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            except_flag <= 1'b0;
        end else if (start && state == ST_IDLE) begin
            except_flag <= except;
        end else if (except && state != ST_IDLE) begin
            except_flag <= 1'b1;
        end
    end

    // Stage 1: registered squares. Sign-extend first so the product is full precision.
    logic signed [31:0] re_ext;
    logic signed [31:0] im_ext;
    logic [31:0]        s1_sq_re;
    logic [31:0]        s1_sq_im;
    logic [9:0]         s1_bin;
    logic               s1_emit;
    logic               s1_done;
    logic               s1_err;

    assign re_ext = {{16{dore[15]}}, dore};
    assign im_ext = {{16{doim[15]}}, doim};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_sq_re <= 32'd0;
            s1_sq_im <= 32'd0;
            s1_bin   <= 10'd0;
            s1_emit  <= 1'b0;
            s1_done  <= 1'b0;
            s1_err   <= 1'b0;
        end else begin
            s1_emit <= accept & ~idx[10];
            s1_done <= accept & (idx == 11'd2047);
            s1_err  <= restart;
            if (accept) begin
                s1_sq_re <= re_ext * re_ext;
                s1_sq_im <= im_ext * im_ext;
                s1_bin   <= idx[9:0];
            end
        end
    end

    // Stage 2: registered sum; data and bin hold while no bin is being emitted.
    logic        p2_valid;
    logic [31:0] p2_data;
    logic [9:0]  p2_bin;
    logic        p2_first;
    logic        p2_last;
    logic        p2_done;
    logic        p2_err;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            p2_valid <= 1'b0;
            p2_data  <= 32'd0;
            p2_bin   <= 10'd0;
            p2_first <= 1'b0;
            p2_last  <= 1'b0;
            p2_done  <= 1'b0;
            p2_err   <= 1'b0;
        end else begin
            p2_valid <= s1_emit;
            p2_first <= s1_emit & (s1_bin == 10'd0);
            p2_last  <= s1_emit & (s1_bin == 10'd1023);
            p2_done  <= s1_done;
            p2_err   <= s1_err;
            if (s1_emit) begin
                p2_data <= s1_sq_re + s1_sq_im;
                p2_bin  <= s1_bin;
            end
        end
    end

`ifdef FFT_PWR_LOG2_EN
    // Stage 3: code = {leading-one position, next 5 bits below it}; zero power gives zero.
    logic [4:0] lead;
    logic [4:0] mant;

    always_comb begin
        lead = 5'd0;
        mant = 5'd0;
        for (int i = 0; i < 32; i++) begin
            if (p2_data[i]) lead = 5'(i);
        end
        for (int j = 0; j < 5; j++) begin
            if (lead > 5'(j)) mant[4-j] = p2_data[lead - 5'(j) - 5'd1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pwr_valid  <= 1'b0;
            pwr_data   <= 32'd0;
            pwr_bin    <= 10'd0;
            pwr_first  <= 1'b0;
            pwr_last   <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            pwr_valid  <= p2_valid;
            pwr_first  <= p2_first;
            pwr_last   <= p2_last;
            frame_done <= p2_done;
            frame_err  <= p2_err;
            if (p2_valid) begin
                pwr_data <= {22'd0, lead, mant};
                pwr_bin  <= p2_bin;
            end
        end
    end
`else
    assign pwr_valid  = p2_valid;
    assign pwr_data   = p2_data;
    assign pwr_bin    = p2_bin;
    assign pwr_first  = p2_first;
    assign pwr_last   = p2_last;
    assign frame_done = p2_done;
    assign frame_err  = p2_err;
`endif

endmodule

// File: doc/fft_power_binner.md
FFT_POWER_BINNER -- requirements
Module: fft_power_binner

Interface
REQ-001 SHALL have port clk, input, 1 bit: system clock; all logic on rising edge.
REQ-002 SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have port obstart, input, 1 bit: FFT output block start; high with bin 0.
REQ-004 SHALL have port outvalid, input, 1 bit: FFT output sample valid.
REQ-005 SHALL have ports dore and doim, input, 16 bits each: signed two's-complement FFT output, real and imaginary.
REQ-006 SHALL have port except, input, 1 bit: FFT exception (overflow) indicator.
REQ-007 SHALL have port pwr_valid, output, 1 bit: pwr_data/pwr_bin valid.
REQ-008 SHALL have port pwr_data, output, 32 bits: unsigned power, or log code (REQ-030).
REQ-009 SHALL have port pwr_bin, output, 10 bits: bin index 0..1023 of pwr_data.
REQ-010 SHALL have ports pwr_first and pwr_last, output, 1 bit each: high with bin 0 and with bin 1023.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse, full 2048-sample block consumed.
REQ-012 SHALL have port frame_err, output, 1 bit: one-cycle pulse, block aborted by early obstart.
REQ-013 SHALL have port except_flag, output, 1 bit: sticky; except seen during current/last frame.

Function
REQ-014 SHALL compute power = dore*dore + doim*doim, full precision, unsigned 32 bits; (-32768,-32768) -> 0x8000_0000, no saturation.
REQ-015 SHALL pipeline: squares registered in stage 1, sum registered in stage 2; pwr_valid exactly 2 cycles after accepted sample (linear mode).
REQ-016 SHALL keep 11-bit sample counter; outvalid with obstart loads index 0; each later outvalid increments.
REQ-017 SHALL emit pwr_valid only for indices 0..1023; indices 1024..2047 consumed silently (real-input symmetry).
REQ-018 SHALL implement FSM IDLE, RUN, DRAIN: IDLE->RUN on outvalid&obstart; RUN->DRAIN after index 1023; DRAIN->IDLE after index 2047.
REQ-019 SHALL ignore outvalid without obstart in IDLE (no output, no counting).
REQ-020 SHALL ignore obstart without outvalid in any state.
REQ-021 SHALL tolerate outvalid gaps in RUN/DRAIN; counter holds, no timeout.
REQ-022 SHALL pulse frame_done in the cycle pwr_valid would appear for index 2047 (2 cycles after that sample).
REQ-023 SHALL, on outvalid&obstart in RUN or DRAIN: pulse frame_err 2 cycles later, restart at index 0 in RUN; samples in pipeline still emitted.
REQ-024 SHALL set except_flag on except high in RUN/DRAIN; clear it at next frame start (obstart in IDLE) unless except high in that cycle.
REQ-025 SHALL align pwr_bin, pwr_first, pwr_last with pwr_data through the same pipeline.
REQ-026 SHALL hold pwr_data/pwr_bin when pwr_valid low; no downstream backpressure.

Reset
REQ-027 SHALL, with rstn low at clk edge: FSM IDLE, counter 0, pipeline valid bits cleared.
REQ-028 SHALL reset all outputs to 0: pwr_valid, pwr_data, pwr_bin, pwr_first, pwr_last, frame_done, frame_err, except_flag.
REQ-029 SHALL, on reset mid-frame, discard partial frame; no frame_done or frame_err for it.

Configuration
REQ-030 SHALL, with FFT_PWR_LOG2_EN defined, add stage 3 giving pwr_data[9:0] = {5-bit leading-one position, 5 bits following mantissa}, pwr_data[31:10]=0; power 0 -> 0; latency 3 cycles; frame_done/frame_err likewise delayed.
REQ-031 SHALL, without FFT_PWR_LOG2_EN, output linear 32-bit power at latency 2; log logic absent.

Verification
REQ-032 SHALL test: reset, obstart+outvalid, 2048 samples dore=3,doim=4 -> 1024 pwr_valid, pwr_data=25, bins 0..1023, pwr_first/last once each, frame_done once.
REQ-033 SHALL test: dore=doim=-32768 at bin 5 -> pwr_data=0x8000_0000 at pwr_bin=5.
REQ-034 SHALL test: obstart+outvalid at index 700 -> frame_err pulse, next output pwr_bin=0 with pwr_first.
REQ-035 SHALL test: random outvalid gaps over 2048-sample frame -> bins contiguous 0..1023, each 2 cycles after its sample.
REQ-036 SHALL test: except pulsed at index 100 -> except_flag high, held to next obstart; rstn low at index 300 -> all outputs 0, no frame_done.
REQ-037 SHALL test, FFT_PWR_LOG2_EN: dore=16,doim=0 (power 256) -> pwr_data=0x100 (8<<5), latency 3.
